v_safe_fsm_monitor: RTL and testbench
=====================================

// Module: v_safe_fsm_monitor
// PURPOSE
//  Supervisor on the far end of a one-hot safe FSM's state bus: samples the state
//  vector each cycle, flags illegal encodings (zero or multiple bits hot), and
//  raises a recovery request after THRESH consecutive illegal samples. It then
//  waits for an acknowledge and checks that the FSM lands in its recovery state
//  within TIMEOUT cycles. Counts illegal samples for status.
//  Its own controller is one-hot with a safe default.
// PARAMETERS
//  WIDTH        5         width of monitored one-hot state vector
//  RECOVERY     5'b10000  one-hot code of the monitored FSM's recovery state
//  THRESH       3         consecutive illegal samples before recovery request (>=1)
//  TIMEOUT      8         cycles allowed after rec_ack to reach RECOVERY (>=1)
//  CNT_W        8         width of saturating illegal-sample counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-high reset
//  en         in   1      monitor enable
//  state_in   in   WIDTH  monitored one-hot state vector
//  rec_ack    in   1      recovery acknowledge from the controlled FSM
//  clr_cnt    in   1      synchronous clear of err_count
//  err        out  1      1-cycle pulse per illegal sample
//  rec_req    out  1      recovery request level, held until rec_ack
//  err_count  out  CNT_W  saturating count of illegal samples
//  bad_state  out  WIDTH  capture of the last illegal sample
//  fatal      out  1      sticky: recovery not reached within TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0; monitor in M_IDLE; the internal sample register s_q is 0.
//  Pipeline: state_in is registered into s_q every cycle. The legality check on s_q is
//   registered, so a sample presented in cycle n drives err in cycle n+2.
//  Illegal: popcount(s_q) != 1. Each illegal sample pulses err, loads bad_state,
//   and increments err_count, saturating at 2**CNT_W-1. err and err_count update
//   only in M_CHECK.
//  clr_cnt takes priority over an increment in the same cycle: the result is 0 and
//   that increment is lost.
//  Monitor states (one-hot):
//   M_IDLE : outputs quiet. en=1 -> M_CHECK.
//   M_CHECK: consec counter +1 on an illegal sample, cleared on a legal one.
//            When consec reaches THRESH -> M_ALARM.
//   M_ALARM: a single cycle. Sets rec_req=1 (registered, visible the next cycle),
//            clears consec, -> M_WAIT.
//   M_WAIT : rec_req held at 1. rec_ack=1 -> rec_req=0, timer=0, -> M_HOLD.
//            There is no timeout in M_WAIT.
//   M_HOLD : s_q==RECOVERY -> M_CHECK. Otherwise timer+1; when the timer reaches
//            TIMEOUT, fatal=1 (sticky until rst) and -> M_IDLE. err is not pulsed in M_HOLD.
//   Any non-one-hot monitor state (default) -> M_IDLE, with rec_req=0.
//  en=0 in any state -> M_IDLE on the next edge. This drops rec_req and clears consec
//   and the timer; err_count, bad_state and fatal are held.
//  Simultaneous events:
//   rec_ack in the same cycle as M_ALARM is ignored; only rec_ack in M_WAIT counts.
//   en rising and an illegal sample in the same cycle: that sample is not counted.
//  Asynchronous rst mid-operation: immediate return to the reset values, fatal included.
// TESTING
//  1 Legal walk: en=1, state_in 00001->00010->00100->01000 -> err=0, err_count=0, rec_req=0.
//  2 Single glitch: a single 00110 sample among legal ones -> err pulses 2 cycles later,
//    err_count=1, bad_state=00110, rec_req stays 0.
//  3 Threshold: 3 consecutive samples of 00000 -> err_count=3; rec_req=1 until rec_ack.
//    Then state_in=10000 -> back to M_CHECK, fatal=0.
//  4 Timeout: after rec_ack, hold state_in=00001 for 8 cycles -> fatal=1, monitor in
//    M_IDLE, rec_req=0.
//  5 Saturation/clear: CNT_W=2 with 5 illegal samples (THRESH large) -> err_count=3.
//    clr_cnt together with an illegal sample -> err_count=0.
//  6 Abort: en=0 while in M_WAIT -> rec_req=0 next cycle, err_count held.
//    Then assert rst async mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/v_safe_fsm_monitor.sv
// Supervisor for a one-hot state bus: flags illegal encodings, requests recovery
// after THRESH consecutive bad samples and checks that recovery lands within TIMEOUT.
module v_safe_fsm_monitor #(
    parameter int              WIDTH    = 5,
    parameter logic [WIDTH-1:0] RECOVERY = 5'b10000,
    parameter int              THRESH   = 3,
    parameter int              TIMEOUT  = 8,
    parameter int              CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] state_in,
    input  logic             rec_ack,
    input  logic             clr_cnt,
    output logic             err,
    output logic             rec_req,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] bad_state,
    output logic             fatal
);

    localparam int CONSEC_W = $clog2(THRESH + 1);
    localparam int TIMER_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [4:0] {
        M_IDLE  = 5'b00001,
        M_CHECK = 5'b00010,
        M_ALARM = 5'b00100,
        M_WAIT  = 5'b01000,
        M_HOLD  = 5'b10000
    } mon_state_e;

    mon_state_e           state_q;
    logic [WIDTH-1:0]     s_q;
    logic [CONSEC_W-1:0]  consec_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 err_q;
    logic                 rec_req_q;
    logic                 fatal_q;
    logic [CNT_W-1:0]     err_count_q;
    logic [WIDTH-1:0]     bad_state_q;

    logic                 s_illegal;
    logic                 count_hit;

    assign s_illegal = ($countones(s_q) != 1);
    assign count_hit = en && (state_q == M_CHECK) && s_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= state_in;
        end
    end

    // A clear in the same cycle as an illegal sample wins; that increment is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (clr_cnt) begin
            err_count_q <= '0;
        end else if (count_hit && (err_count_q != CNT_MAX)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= M_IDLE;
            consec_q    <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            rec_req_q   <= 1'b0;
            fatal_q     <= 1'b0;
            bad_state_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (!en) begin
                state_q   <= M_IDLE;
                rec_req_q <= 1'b0;
                consec_q  <= '0;
                timer_q   <= '0;
            end else begin
                case (state_q)
                    M_IDLE: begin
                        state_q <= M_CHECK;
                    end
                    M_CHECK: begin
                        if (s_illegal) begin
                            err_q       <= 1'b1;
                            bad_state_q <= s_q;
                            if (consec_q == CONSEC_W'(THRESH - 1)) begin
                                consec_q <= CONSEC_W'(THRESH);
                                state_q  <= M_ALARM;
                            end else begin
                                consec_q <= consec_q + 1'b1;
                            end
                        end else begin
                            consec_q <= '0;
                        end
                    end
                    M_ALARM: begin
                        rec_req_q <= 1'b1;
                        consec_q  <= '0;
                        state_q   <= M_WAIT;
                    end
                    M_WAIT: begin
                        if (rec_ack) begin
                            rec_req_q <= 1'b0;
                            timer_q   <= '0;
                            state_q   <= M_HOLD;
                        end
                    end
                    M_HOLD: begin
                        if (s_q == RECOVERY) begin
                            state_q <= M_CHECK;
                        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                            timer_q <= TIMER_W'(TIMEOUT);
                            fatal_q <= 1'b1;
                            state_q <= M_IDLE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: begin
                        // Corrupted controller encoding: fall back to a quiet idle.
                        state_q   <= M_IDLE;
                        rec_req_q <= 1'b0;
                        consec_q  <= '0;
                        timer_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign err       = err_q;
    assign rec_req   = rec_req_q;
    assign err_count = err_count_q;
    assign bad_state = bad_state_q;
    assign fatal     = fatal_q;

endmodule

// File: tb/tb_v_safe_fsm_monitor.sv
// Scoreboard bench for v_safe_fsm_monitor: default instance plus a small-counter,
// high-threshold instance for saturation and clear.
module tb_v_safe_fsm_monitor;

    typedef struct {
        int         cyc;
        logic       err;
        logic [4:0] bad;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, rec_ack = 1'b0, clr_cnt = 1'b0;
    logic [4:0] state_in = 5'b00001;
    logic       err, rec_req, fatal;
    logic [7:0] err_count;
    logic [4:0] bad_state;

    logic       en2 = 1'b0, ack2 = 1'b0, clr2 = 1'b0;
    logic [4:0] st2 = 5'b00001;
    logic       err2, rec_req2, fatal2;
    logic [1:0] err_count2;
    logic [4:0] bad_state2;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];
    logic [4:0] exp_bad = 5'b0;
    logic [4:0] exp_bad2 = 5'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    v_safe_fsm_monitor dut (
        .clk(clk), .rst(rst), .en(en), .state_in(state_in), .rec_ack(rec_ack),
        .clr_cnt(clr_cnt), .err(err), .rec_req(rec_req), .err_count(err_count),
        .bad_state(bad_state), .fatal(fatal)
    );

    v_safe_fsm_monitor #(.THRESH(100), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en2), .state_in(st2), .rec_ack(ack2),
        .clr_cnt(clr2), .err(err2), .rec_req(rec_req2), .err_count(err_count2),
        .bad_state(bad_state2), .fatal(fatal2)
    );

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", err); end
        vectors++; if (rec_req !== 1'b0) begin miscompares++; $display("FAIL reset_rec_req got %0b want 0", rec_req); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        vectors++; if (bad_state !== 5'b0) begin miscompares++; $display("FAIL reset_bad_state got %b want 00000", bad_state); end
        vectors++; if (fatal !== 1'b0) begin miscompares++; $display("FAIL reset_fatal got %0b want 0", fatal); end
    endtask

    task automatic test_legal_walk();
        logic [4:0] pat [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
        exp_t e;
        @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                vectors++; if (err !== e.err) begin miscompares++; $display("FAIL walk_err got %0b want %0b", err, e.err); end
            end
            if (i < 4) begin
                state_in = pat[i];
                exp_q.push_back('{cyc + 2, 1'b0, exp_bad});
            end
        end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL walk_err_count got %0d want 0", err_count); end
        vectors++; if (rec_req !== 1'b0) begin miscompares++; $display("FAIL walk_rec_req got %0b want 0", rec_req); end
    endtask

    task automatic test_glitch();
        logic [4:0] pat [4] = '{5'b00001, 5'b00110, 5'b00010, 5'b00100};
        logic       pe  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                vectors++; if (err !== e.err) begin miscompares++; $display("FAIL glitch_err got %0b want %0b", err, e.err); end
                vectors++; if (bad_state !== e.bad) begin miscompares++; $display("FAIL glitch_bad got %b want %b", bad_state, e.bad); end
            end
            if (i < 4) begin
                state_in = pat[i];
                if (pe[i]) exp_bad = pat[i];
                exp_q.push_back('{cyc + 2, pe[i], exp_bad});
            end
        end
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL glitch_err_count got %0d want 1", err_count); end
        vectors++; if (rec_req !== 1'b0) begin miscompares++; $display("FAIL glitch_rec_req got %0b want 0", rec_req); end
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL clear_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_threshold();
        logic [4:0] pat [6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00001};
        logic       pe  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                vectors++; if (err !== e.err) begin miscompares++; $display("FAIL thresh_err got %0b want %0b", err, e.err); end
                vectors++; if (bad_state !== e.bad) begin miscompares++; $display("FAIL thresh_bad got %b want %b", bad_state, e.bad); end
            end
            if (i < 6) begin
                state_in = pat[i];
                if (pe[i]) exp_bad = pat[i];
                exp_q.push_back('{cyc + 2, pe[i], exp_bad});
            end
        end
        vectors++; if (err_count !== 8'd3) begin miscompares++; $display("FAIL thresh_err_count got %0d want 3", err_count); end
        vectors++; if (rec_req !== 1'b1) begin miscompares++; $display("FAIL thresh_rec_req got %0b want 1", rec_req); end
        repeat (12) @(negedge clk);
        vectors++; if (rec_req !== 1'b1) begin miscompares++; $display("FAIL wait_no_timeout got %0b want 1", rec_req); end
        vectors++; if (fatal !== 1'b0) begin miscompares++; $display("FAIL wait_fatal got %0b want 0", fatal); end
        rec_ack  = 1'b1;
        state_in = 5'b10000;
        @(negedge clk);
        rec_ack = 1'b0;
        vectors++; if (rec_req !== 1'b0) begin miscompares++; $display("FAIL ack_rec_req got %0b want 0", rec_req); end
        repeat (10) @(negedge clk);
        vectors++; if (fatal !== 1'b0) begin miscompares++; $display("FAIL recover_fatal got %0b want 0", fatal); end
        state_in = 5'b00011;
        @(negedge clk);
        state_in = 5'b10000;
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL recheck_err got %0b want 1", err); end
        vectors++; if (bad_state !== 5'b00011) begin miscompares++; $display("FAIL recheck_bad got %b want 00011", bad_state); end
        vectors++; if (err_count !== 8'd4) begin miscompares++; $display("FAIL recheck_err_count got %0d want 4", err_count); end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            state_in = (i < 3) ? 5'b00000 : 5'b00001;
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (rec_req === 1'b1);
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL timeout_rec_req got 0 want 1 within 10 cycles"); end
        vectors++; if (err_count !== 8'd7) begin miscompares++; $display("FAIL timeout_err_count got %0d want 7", err_count); end
        @(negedge clk);
        rec_ack = 1'b1;
        @(negedge clk);
        rec_ack = 1'b0;
        repeat (7) @(negedge clk);
        vectors++; if (fatal !== 1'b0) begin miscompares++; $display("FAIL timeout_early_fatal got %0b want 0", fatal); end
        state_in = 5'b00000;
        @(negedge clk);
        vectors++; if (fatal !== 1'b1) begin miscompares++; $display("FAIL timeout_fatal got %0b want 1", fatal); end
        vectors++; if (rec_req !== 1'b0) begin miscompares++; $display("FAIL timeout_rec_req_low got %0b want 0", rec_req); end
        state_in = 5'b00001;
        @(negedge clk);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL idle_err got %0b want 0", err); end
        @(negedge clk);
        vectors++; if (err_count !== 8'd7) begin miscompares++; $display("FAIL idle_err_count got %0d want 7", err_count); end
    endtask

    task automatic test_saturation();
        logic [4:0] pat [7] = '{5'b00011, 5'b00000, 5'b11111, 5'b00101, 5'b01100, 5'b00001, 5'b00001};
        logic       pe  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_t e;
        @(negedge clk);
        en2 = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (exp2_q.size() > 0 && exp2_q[0].cyc <= cyc) begin
                e = exp2_q.pop_front();
                vectors++; if (err2 !== e.err) begin miscompares++; $display("FAIL sat_err got %0b want %0b", err2, e.err); end
                vectors++; if (bad_state2 !== e.bad) begin miscompares++; $display("FAIL sat_bad got %b want %b", bad_state2, e.bad); end
            end
            if (i < 7) begin
                st2 = pat[i];
                if (pe[i]) exp_bad2 = pat[i];
                exp2_q.push_back('{cyc + 2, pe[i], exp_bad2});
            end
        end
        vectors++; if (err_count2 !== 2'd3) begin miscompares++; $display("FAIL sat_err_count got %0d want 3", err_count2); end
        vectors++; if (rec_req2 !== 1'b0) begin miscompares++; $display("FAIL sat_rec_req got %0b want 0", rec_req2); end
        st2 = 5'b00000;
        @(negedge clk);
        st2  = 5'b00001;
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        vectors++; if (err_count2 !== 2'd0) begin miscompares++; $display("FAIL clr_vs_inc got %0d want 0", err_count2); end
        vectors++; if (err2 !== 1'b1) begin miscompares++; $display("FAIL clr_err_pulse got %0b want 1", err2); end
        @(negedge clk);
        vectors++; if (err_count2 !== 2'd0) begin miscompares++; $display("FAIL clr_hold got %0d want 0", err_count2); end
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            state_in = (i < 3) ? 5'b00000 : 5'b00001;
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (rec_req === 1'b1);
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL abort_rec_req got 0 want 1 within 10 cycles"); end
        en = 1'b0;
        @(negedge clk);
        vectors++; if (rec_req !== 1'b0) begin miscompares++; $display("FAIL abort_rec_req_drop got %0b want 0", rec_req); end
        vectors++; if (err_count !== 8'd10) begin miscompares++; $display("FAIL abort_err_count got %0d want 10", err_count); end
        vectors++; if (fatal !== 1'b1) begin miscompares++; $display("FAIL abort_fatal_held got %0b want 1", fatal); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL async_err_count got %0d want 0", err_count); end
        vectors++; if (bad_state !== 5'b0) begin miscompares++; $display("FAIL async_bad_state got %b want 00000", bad_state); end
        vectors++; if (fatal !== 1'b0) begin miscompares++; $display("FAIL async_fatal got %0b want 0", fatal); end
        vectors++; if (rec_req !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL async_req_err got %0b%0b want 00", rec_req, err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal_walk();
        test_glitch();
        test_threshold();
        test_timeout();
        test_saturation();
        test_abort();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
